// File: rtl/frame_sync_ctrl.sv
// Purpose : frame-alignment controller that runs hunt/verify/lock/flywheel on the
//           locater's pattern-detect pulse and publishes lock status and aligned position.
// Latency : all outputs are registered, one cycle after the capture or checkpoint cycle.
// Backpress: none; PDET and LOC are consumed every cycle, and outputs are level/pulse.
//
// Ports   : CLK, RST_N (async active-low) ; PDET pulse + LOC position in ;
//           LOCKED, ALIGN_LOC, FRAME_STROBE, STATE, LOSS_CNT out.
// Build   : define FRAME_SYNC_STATS_EN to build the saturating LOSS_CNT register;
//           otherwise LOSS_CNT reads as zero.
module frame_sync_ctrl #(
  parameter int FRAME_LEN  = 20,
  parameter int LOC_W      = 5,
  parameter int VERIFY_CNT = 3,
  parameter int MISS_CNT   = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PDET,
  input  logic [LOC_W-1:0] LOC,
  output logic             LOCKED,
  output logic [LOC_W-1:0] ALIGN_LOC,
  output logic             FRAME_STROBE,
  output logic [1:0]       STATE,
  output logic [7:0]       LOSS_CNT
);

  localparam logic [1:0] ST_HUNT     = 2'd0;
  localparam logic [1:0] ST_VERIFY   = 2'd1;
  localparam logic [1:0] ST_LOCK     = 2'd2;
  localparam logic [1:0] ST_FLYWHEEL = 2'd3;

  localparam int HIT_W  = $clog2(VERIFY_CNT + 1);
  localparam int MISS_W = $clog2(MISS_CNT + 1);

  // Parameter sanity, caught at elaboration.
  if ((2 ** LOC_W) < FRAME_LEN) begin : g_bad_loc_w
    $error("frame_sync_ctrl: LOC_W too narrow for FRAME_LEN");
  end
  if (VERIFY_CNT < 1 || MISS_CNT < 1) begin : g_bad_cnt
    $error("frame_sync_ctrl: VERIFY_CNT and MISS_CNT must be >= 1");
  end

  logic [1:0]        state_q, state_d;
  logic [LOC_W-1:0]  align_loc_q, align_loc_d;
  logic [HIT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic              strobe_q, strobe_d;
  logic              locked_q, locked_d;
  logic              checkpoint;

  // A checkpoint is the cycle where the locater is at the expected pattern position.
  assign checkpoint = (state_q != ST_HUNT) && (LOC == align_loc_q);

  always_comb begin
    state_d     = state_q;
    align_loc_d = align_loc_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    strobe_d    = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (PDET) begin
          align_loc_d = LOC;
          hit_cnt_d   = HIT_W'(1);
          if (VERIFY_CNT == 1) begin
            // A single hit is enough: lock is declared straight from the capture.
            state_d    = ST_LOCK;
            miss_cnt_d = '0;
            strobe_d   = 1'b1;
          end else begin
            state_d = ST_VERIFY;
          end
        end
      end
      ST_VERIFY: begin
        if (checkpoint) begin
          if (PDET) begin
            hit_cnt_d = hit_cnt_q + HIT_W'(1);
            if (hit_cnt_d == HIT_W'(VERIFY_CNT)) begin
              state_d    = ST_LOCK;
              miss_cnt_d = '0;
              strobe_d   = 1'b1;
            end
          end else begin
            // ALIGN_LOC is deliberately kept; HUNT overwrites it on the next capture.
            state_d   = ST_HUNT;
            hit_cnt_d = '0;
          end
        end
      end
      ST_LOCK: begin
        if (checkpoint) begin
          if (PDET) begin
            strobe_d = 1'b1;
          end else begin
            miss_cnt_d = MISS_W'(1);
            if (MISS_CNT == 1) begin
              state_d   = ST_HUNT;
              hit_cnt_d = '0;
            end else begin
              state_d  = ST_FLYWHEEL;
              strobe_d = 1'b1;
            end
          end
        end
      end
      default: begin // ST_FLYWHEEL
        if (checkpoint) begin
          if (PDET) begin
            state_d    = ST_LOCK;
            miss_cnt_d = '0;
            strobe_d   = 1'b1;
          end else begin
            miss_cnt_d = miss_cnt_q + MISS_W'(1);
            if (miss_cnt_d == MISS_W'(MISS_CNT)) begin
              state_d   = ST_HUNT;
              hit_cnt_d = '0;
            end else begin
              strobe_d = 1'b1;
            end
          end
        end
      end
    endcase

    // LOCK and FLYWHEEL share the upper state bit.
    locked_d = state_d[1];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_HUNT;
      align_loc_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      strobe_q    <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_loc_q <= align_loc_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      strobe_q    <= strobe_d;
      locked_q    <= locked_d;
    end
  end

  assign STATE        = state_q;
  assign LOCKED       = locked_q;
  assign ALIGN_LOC    = align_loc_q;
  assign FRAME_STROBE = strobe_q;

`ifdef FRAME_SYNC_STATS_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;
  logic       lose_lock;

  // Any exit from LOCK/FLYWHEEL back to HUNT is one loss of alignment.
  assign lose_lock = state_q[1] && (state_d == ST_HUNT);

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lose_lock && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      loss_cnt_q <= 8'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign LOSS_CNT = loss_cnt_q;
`else
  assign LOSS_CNT = 8'd0;
`endif

endmodule

// File: doc/frame_sync_ctrl.md
# frame_sync_ctrl

Frame-alignment controller for the serial frame detector. It watches the pattern-detect pulse (PDET) and the in-frame position (LOC) from the pattern locater and runs a hunt/verify/lock/flywheel state machine. It declares frame lock only after the pattern repeats at the same position in consecutive frames, and it holds lock through isolated misses. It drives the lock status, the aligned position and a per-frame strobe to downstream frame consumers.

## Interface
- FRAME_LEN, 20, frame length in bits; LOC counts 0..FRAME_LEN-1.
- LOC_W, 5, width of LOC and ALIGN_LOC; must satisfy 2^LOC_W >= FRAME_LEN.
- VERIFY_CNT, 3, consecutive same-position hits, including the first, needed to lock (>=1).
- MISS_CNT, 2, consecutive checkpoint misses that drop lock (>=1).

Ports:
- CLK  in  1  rising-edge clock, shared with the pattern locater.
- RST_N  in  1  asynchronous, active-low reset.
- PDET  in  1  one-cycle pattern-detect pulse from the locater.
- LOC  in  LOC_W  current bit position within the frame.
- LOCKED  out  1  frame alignment valid; high in LOCK and FLYWHEEL.
- ALIGN_LOC  out  LOC_W  LOC value captured at the pattern position.
- FRAME_STROBE  out  1  one-cycle pulse per aligned frame.
- STATE  out  2  HUNT=0, VERIFY=1, LOCK=2, FLYWHEEL=3.
- LOSS_CNT  out  8  saturating count of lock losses (see Configuration).

## Operation
- Checkpoint cycle: any cycle in VERIFY, LOCK or FLYWHEEL with LOC == ALIGN_LOC. PDET in non-checkpoint cycles is ignored in those states.
- Internal counters:
  - hit_cnt: range 0..VERIFY_CNT.
  - miss_cnt: range 0..MISS_CNT.
- HUNT: on PDET=1:
  - ALIGN_LOC <= LOC, hit_cnt <= 1.
  - Next state is LOCK if VERIFY_CNT==1, otherwise VERIFY.
- VERIFY, at each checkpoint:
  - PDET=1: hit_cnt++. When the incremented value equals VERIFY_CNT, go to LOCK with miss_cnt <= 0.
  - PDET=0: go to HUNT, hit_cnt <= 0. ALIGN_LOC keeps its old value.
- LOCK, at each checkpoint:
  - PDET=1: stay in LOCK.
  - PDET=0: miss_cnt <= 1. Go to FLYWHEEL, or straight to HUNT if MISS_CNT==1.
- FLYWHEEL, at each checkpoint:
  - PDET=1: go to LOCK, miss_cnt <= 0.
  - PDET=0: miss_cnt++. When it reaches MISS_CNT, go to HUNT and count one loss.
- HUNT does not re-capture in the same cycle that it is entered. A PDET on that cycle is the failing checkpoint and is consumed by it.
- LOSS_CNT: increments by one on every LOCK/FLYWHEEL -> HUNT transition and saturates at 255.
- Off-range LOC (>= FRAME_LEN) gets no special handling; it is compared like any other value.

## Timing
- All outputs are registered. STATE, LOCKED and ALIGN_LOC reflect a decision one cycle after the checkpoint or capture cycle.
- FRAME_STROBE:
  - Asserted in the cycle after a checkpoint whose next state is LOCK or FLYWHEEL, including the cycle in which lock is first declared.
  - Never high for two consecutive cycles when FRAME_LEN >= 2.
  - Not asserted on the checkpoint that drops to HUNT.
- Lock latency: LOCKED rises one cycle after the VERIFY_CNT-th hit, i.e. (VERIFY_CNT-1)*FRAME_LEN + 1 cycles after the first PDET.
- Loss latency: LOCKED falls one cycle after the MISS_CNT-th consecutive missed checkpoint.
- Reset values, applied asynchronously when RST_N=0: STATE=0, LOCKED=0, ALIGN_LOC=0, FRAME_STROBE=0, LOSS_CNT=0, hit_cnt=0, miss_cnt=0.
- Reset mid-operation drops lock immediately, with no strobe. Release is synchronous to CLK, and the first capture is possible on the first edge after release.

## Configuration
- FRAME_SYNC_STATS_EN defined: the LOSS_CNT register and its increment logic are built as described above.
- FRAME_SYNC_STATS_EN undefined: LOSS_CNT is tied to 8'd0 and the register is not built. All other behaviour is identical.

## Test plan
All scenarios use the default parameters (FRAME_LEN=20, VERIFY_CNT=3, MISS_CNT=2).
- Reset: hold RST_N=0 for 3 cycles, then release.
  - Required: STATE=0, LOCKED=0, ALIGN_LOC=0, LOSS_CNT=0, FRAME_STROBE=0.
- Acquire: PDET at LOC=7 in three consecutive frames.
  - STATE=1 and ALIGN_LOC=7 one cycle after the first hit.
  - LOCKED=1, STATE=2 and one FRAME_STROBE pulse one cycle after the third hit, 41 cycles after the first PDET.
- Verify failure: PDET at LOC=7, no PDET at LOC=7 in the next frame, then PDET at LOC=12.
  - STATE 1 -> 0 after the missed checkpoint.
  - ALIGN_LOC=12 and STATE=1 after the LOC=12 pulse.
- Flywheel: locked at LOC=7, one frame without PDET, then pulses resume.
  - STATE=3 with LOCKED held at 1 and FRAME_STROBE still pulsing.
  - STATE returns to 2 at the next hit.
- Loss: locked, then two consecutive misses.
  - LOCKED=0 and STATE=0 one cycle after the second miss, with no strobe on that frame.
  - LOSS_CNT 0 -> 1 with FRAME_SYNC_STATS_EN defined; stays 0 without it.
- Async reset: drop RST_N mid-cycle while in LOCK.
  - All outputs clear before the next CLK edge.
  - Re-acquire after release matches the Acquire scenario.
